// File: rtl/mem_data_register.sv
// Memory data register: waits on the read-data handshake, captures the
// beat, then extracts and extends the addressed byte/half/word/beat.
module mem_data_register #(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [DATA_W-1:0] in_mem,
  input  logic              mem_valid,
  output logic              busy,
  output logic [DATA_W-1:0] out_mem,
  output logic              out_valid,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t             state;
  state_t             state_nx;
  logic [7:0]         cnt;
  logic [1:0]         sz_q;
  logic               sx_q;
  logic [OFF_W-1:0]   a_q;
  logic               mis;
  logic               expired;
  logic [DATA_W-1:0]  sh;
  logic [DATA_W-1:0]  ext;
  int                 nb;
  logic               msb;
  logic               fill;

  assign busy    = (state == S_WAIT);
  assign expired = (cnt == LAST);

  // Alignment check on the live request fields.
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (size == 2'd1): mis = addr_lo[0];
      (size == 2'd2): mis = (addr_lo[1:0] != 2'd0);
      (size == 2'd3): mis = (addr_lo != '0);
      default:        mis = 1'b0;
    endcase
  end

  // Lane select by byte shift, then field width and fill bit.
  always_comb begin
    sh  = in_mem >> {a_q, 3'b000};
    nb  = DATA_W;
    msb = 1'b0;
    unique case (sz_q)
      2'd0: begin
        nb  = 8;
        msb = sh[7];
      end
      2'd1: begin
        nb  = 16;
        msb = sh[15];
      end
      2'd2: begin
        nb  = 32;
        msb = sh[31];
      end
      default: begin
        nb  = DATA_W;
        msb = 1'b0;
      end
    endcase
    fill = sx_q & msb;
    ext  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < nb) ? sh[i] : fill;
    end
  end

  // Next state: leave WAIT on data or on wait-limit expiry.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (req && !mis) state_nx = S_WAIT;
      S_WAIT: if (mem_valid || expired) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Request latch, wait counter, data capture and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      sz_q         <= '0;
      sx_q         <= 1'b0;
      a_q          <= '0;
      out_mem      <= '0;
      out_valid    <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      if (state == S_IDLE) begin
        if (req) begin
          if (mis) begin
            err_misalign <= 1'b1;
          end else begin
            sz_q <= size;
            sx_q <= sign_ext;
            a_q  <= addr_lo;
            cnt  <= '0;
          end
        end
      end else if (mem_valid) begin
        out_mem   <= ext;
        out_valid <= 1'b1;
      end else if (expired) begin
        err_timeout <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_register.sv
// Bench for mem_data_register: 32-bit and 64-bit instances share stimulus
// and are checked every cycle against a transaction-level model.
module tb_mem_data_register;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  size;
  logic        sign_ext;
  logic [2:0]  addr;
  logic [63:0] in_mem;
  logic        mem_valid;

  logic        b32, v32, em32, et32;
  logic [31:0] o32;
  logic        b64, v64, em64, et64;
  logic [63:0] o64;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  logic        m_busy [2];
  logic [63:0] m_out  [2];
  logic        m_ov   [2];
  logic        m_em   [2];
  logic        m_et   [2];
  int          m_wait [2];
  logic [1:0]  m_sz   [2];
  logic        m_sx   [2];
  int          m_a    [2];

  always #5 clk = ~clk;

  mem_data_register #(.DATA_W(32), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst), .req(req), .size(size),
    .sign_ext(sign_ext), .addr_lo(addr[1:0]),
    .in_mem(in_mem[31:0]), .mem_valid(mem_valid),
    .busy(b32), .out_mem(o32), .out_valid(v32),
    .err_misalign(em32), .err_timeout(et32)
  );

  mem_data_register #(.DATA_W(64), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst), .req(req), .size(size),
    .sign_ext(sign_ext), .addr_lo(addr),
    .in_mem(in_mem), .mem_valid(mem_valid),
    .busy(b64), .out_mem(o64), .out_valid(v64),
    .err_misalign(em64), .err_timeout(et64)
  );

  function automatic int nbytes(logic [1:0] sz, int dw);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return dw / 8;
    endcase
  endfunction

  function automatic logic [63:0] extract(logic [63:0] d, logic [1:0] sz,
                                          logic sx, int a, int dw);
    int          n;
    logic [63:0] v;
    logic [63:0] m;
    n = nbytes(sz, dw);
    v = d >> (8 * a);
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (sx && v[8*n-1]) v = v | ~m;
    end
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic mstep(input int k);
    int          dw;
    int          a;
    logic [63:0] d;
    dw = (k == 0) ? 32 : 64;
    a  = int'(addr) % (dw / 8);
    d  = (dw == 32) ? {32'd0, in_mem[31:0]} : in_mem;
    if (rst) begin
      m_busy[k] = 1'b0;
      m_out[k]  = '0;
      m_ov[k]   = 1'b0;
      m_em[k]   = 1'b0;
      m_et[k]   = 1'b0;
      m_wait[k] = 0;
    end else begin
      m_ov[k] = 1'b0;
      m_em[k] = 1'b0;
      m_et[k] = 1'b0;
      if (!m_busy[k]) begin
        if (req) begin
          if (a % nbytes(size, dw) != 0) begin
            m_em[k] = 1'b1;
          end else begin
            m_busy[k] = 1'b1;
            m_wait[k] = 0;
            m_sz[k]   = size;
            m_sx[k]   = sign_ext;
            m_a[k]    = a;
          end
        end
      end else if (mem_valid) begin
        m_out[k]  = extract(d, m_sz[k], m_sx[k], m_a[k], dw);
        m_ov[k]   = 1'b1;
        m_busy[k] = 1'b0;
      end else begin
        m_wait[k]++;
        if (m_wait[k] == TO) begin
          m_et[k]   = 1'b1;
          m_busy[k] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (armed) begin
      chk("busy32", 64'(b32), 64'(m_busy[0]));
      chk("out32", {32'd0, o32}, m_out[0]);
      chk("oval32", 64'(v32), 64'(m_ov[0]));
      chk("emis32", 64'(em32), 64'(m_em[0]));
      chk("etmo32", 64'(et32), 64'(m_et[0]));
      chk("busy64", 64'(b64), 64'(m_busy[1]));
      chk("out64", o64, m_out[1]);
      chk("oval64", 64'(v64), 64'(m_ov[1]));
      chk("emis64", 64'(em64), 64'(m_em[1]));
      chk("etmo64", 64'(et64), 64'(m_et[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sz, input logic sx,
                      input logic [2:0] a, input logic [63:0] d);
    tick();
    req      = 1'b1;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    tick();
    req       = 1'b0;
    mem_valid = 1'b1;
    in_mem    = d;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic misreq(input logic [1:0] sz, input logic [2:0] a);
    tick();
    req  = 1'b1;
    size = sz;
    addr = a;
    tick();
    req = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    size      = 2'd0;
    sign_ext  = 1'b0;
    addr      = '0;
    in_mem    = '0;
    mem_valid = 1'b0;
    tick();
    tick();
    armed = 1'b1;
    rst   = 1'b0;
    mem_valid = 1'b1;
    in_mem    = 64'h0000_0000_DEAD_BEEF;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("pin_rst_out", {32'd0, o32}, 64'd0);
    chk("pin_rst_busy", 64'(b32), 64'd0);

    load(2'd2, 1'b0, 3'd0, 64'd34);
    chk("pin_word_out", {32'd0, o32}, 64'd34);
    chk("pin_word_v", 64'(v32), 64'd1);

    load(2'd0, 1'b1, 3'd0, 64'h0000_0000_80F0_7F85);
    chk("pin_b0s", {32'd0, o32}, 64'h0000_0000_FFFF_FF85);
    load(2'd0, 1'b0, 3'd0, 64'h0000_0000_80F0_7F85);
    chk("pin_b0u", {32'd0, o32}, 64'h0000_0000_0000_0085);
    load(2'd0, 1'b1, 3'd3, 64'h0000_0000_80F0_7F85);
    chk("pin_b3s", {32'd0, o32}, 64'h0000_0000_FFFF_FF80);
    load(2'd1, 1'b1, 3'd2, 64'h0000_0000_80F0_7F85);
    chk("pin_h2s", {32'd0, o32}, 64'h0000_0000_FFFF_80F0);
    load(2'd1, 1'b0, 3'd2, 64'h0000_0000_80F0_7F85);
    chk("pin_h2u", {32'd0, o32}, 64'h0000_0000_0000_80F0);

    misreq(2'd1, 3'd1);
    chk("pin_mis_h", 64'(em32), 64'd1);
    chk("pin_mis_keep", {32'd0, o32}, 64'h0000_0000_0000_80F0);
    misreq(2'd2, 3'd2);
    chk("pin_mis_w", 64'(em32), 64'd1);
    chk("pin_mis_busy", 64'(b32), 64'd0);

    tick();
    req  = 1'b1;
    size = 2'd2;
    addr = 3'd0;
    tick();
    req = 1'b0;
    repeat (4) tick();
    chk("pin_tmo", 64'(et32), 64'd1);

    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    mem_valid = 1'b1;
    in_mem    = 64'h0000_0000_0000_0055;
    tick();
    mem_valid = 1'b0;
    chk("pin_last_v", 64'(v32), 64'd1);
    chk("pin_last_e", 64'(et32), 64'd0);

    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("pin_abort_out", {32'd0, o32}, 64'd0);
    chk("pin_abort_busy", 64'(b32), 64'd0);

    load(2'd3, 1'b1, 3'd0, 64'h0123_4567_89AB_CDEF);
    chk("pin_full64", o64, 64'h0123_4567_89AB_CDEF);
    load(2'd2, 1'b1, 3'd4, 64'h0123_4567_89AB_CDEF);
    chk("pin_w4s64", o64, 64'h0000_0000_0123_4567);
    load(2'd2, 1'b1, 3'd4, 64'h89AB_CDEF_0123_4567);
    chk("pin_w4n64", o64, 64'hFFFF_FFFF_89AB_CDEF);

    tick();
    req  = 1'b1;
    size = 2'd0;
    addr = 3'd5;
    tick();
    tick();
    mem_valid = 1'b1;
    in_mem    = 64'hA1B2_C3D4_E5F6_0718;
    tick();
    req       = 1'b0;
    mem_valid = 1'b0;
    repeat (6) tick();

    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int x = 0; x < 2; x++) begin
          load(2'(s), 1'(x), 3'(a), 64'h8F70_E15A_7B93_C4D6);
        end
      end
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
